decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Pipeline ID stage: decodes a 32-bit RV32 instruction into the ALU command (AluOp, a, b) and
//  writeback info, then registers it into the ID/EX pipeline register that drives the ALU.
//  Sits between IF (instr/pc) and EX (alu). Generates only AluOp encodings the ALU implements.
// PARAMETERS
//  ILLEGAL_AS_NOP  0  1: unsupported instr leaves out_valid=0; 0: out_valid=1 with out_illegal=1
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-high
//  in_valid      in   1   instr/pc valid from IF
//  in_instr      in   32  instruction word
//  in_pc         in   32  pc of in_instr
//  stall         in   1   hold ID/EX register (hazard unit)
//  flush         in   1   squash ID/EX contents (branch/exception)
//  in_ready      out  1   combinational: !stall
//  rf_rs1_addr   out  5   combinational: in_instr[19:15]
//  rf_rs2_addr   out  5   combinational: in_instr[24:20]
//  rf_rs1_data   in   32  regfile read data (same cycle)
//  rf_rs2_data   in   32  regfile read data (same cycle)
//  out_valid     out  1   ID/EX entry valid
//  out_alu_op    out  3   AluOp: AND=0 OR=1 ADD=2 XOR=3 SHL=4 SHR=5 SUB=6 SLT=7
//  out_a         out  32  ALU operand a
//  out_b         out  32  ALU operand b
//  out_rd        out  5   destination register
//  out_reg_write out  1   writeback enable
//  out_illegal   out  1   unsupported instruction flag
// BEHAVIOUR
//  - Reset values: out_valid=0, out_alu_op=ADD(2), out_a=0, out_b=0, out_rd=0,
//    out_reg_write=0, out_illegal=0. Reset overrides flush and stall.
//  - Register update priority per posedge: reset > flush > stall > capture.
//    flush: out_valid=0, out_reg_write=0, out_illegal=0; other fields don't-care. Wins over stall.
//    stall: every output holds its value; input instr is not consumed.
//    capture: out_valid=in_valid, decoded fields loaded. Latency 1 cycle.
//  - in_valid=0 on capture: out_valid=0, out_reg_write=0, out_illegal=0.
//  - Decode (opcode in_instr[6:0]); immI = sign-ext instr[31:20]; immU = {instr[31:12],12'b0}:
//    OP 0110011, funct7=0000000: f3 000 ADD,001 SHL,011 SLT(sltu),100 XOR,101 SHR,110 OR,111 AND;
//      funct7=0100000 & f3=000: SUB. a=rs1_data, b=rs2_data.
//    OP-IMM 0010011: f3 000 ADD,011 SLT(sltiu),100 XOR,110 OR,111 AND: a=rs1_data, b=immI;
//      f3 001 SHL / 101 SHR need instr[31:25]=0000000; b={27'b0,instr[24:20]}.
//    LUI 0110111: ADD, a=0, b=immU.   AUIPC 0010111: ADD, a=in_pc, b=immU.
//  - ALU SLT is unsigned; only sltu/sltiu map to SLT. Signed slt/slti (f3 010), SRA/SRAI, all
//    other opcodes/funct7 combos are unsupported.
//  - Unsupported: out_alu_op=ADD, out_reg_write=0; out_illegal=1 & out_valid=in_valid
//    (ILLEGAL_AS_NOP=0) or out_illegal=0 & out_valid=0 (ILLEGAL_AS_NOP=1).
//  - out_reg_write=1 only for valid supported instr with rd!=0; rd=0 -> 0 (x0 never written).
//  - All arithmetic 32-bit; immediates sign-extended from bit 31; no overflow detection.
// TESTING
//  1. ADD x3,x1,x2 (0x002081B3), rs1=10, rs2=7, in_valid=1 -> next cycle out_valid=1, op=2,
//     a=10, b=7, rd=3, reg_write=1, illegal=0; rf_rs1_addr=1, rf_rs2_addr=2 same cycle.
//  2. SUB x1,x2,x3 (0x403100B3) -> op=6; ADDI x5,x0,-1 (0xFFF00293) -> op=2, b=0xFFFFFFFF, rd=5;
//     SLLI x1,x1,3 (0x00309093) -> op=4, b=3; LUI/AUIPC pc=0x100 imm 0x12345 -> b=0x12345000,
//     a=0 / a=0x100.
//  3. SLT x3,x1,x2 (0x0020A1B3) -> out_valid=1, out_illegal=1, reg_write=0, op=2; with
//     ILLEGAL_AS_NOP=1 -> out_valid=0, out_illegal=0.
//  4. Capture ADD, then stall=1 for 3 cycles while in_instr changes -> outputs frozen, in_ready=0;
//     stall drop -> next instr captured 1 cycle later.
//  5. stall=1 and flush=1 same cycle -> out_valid=0, reg_write=0 next cycle; ADD x0,x1,x2
//     (0x00208033) -> out_valid=1, reg_write=0.
//  6. reset asserted with valid entry held by stall -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/decode_stage.sv
// Purpose: RV32 ID stage - decodes an instruction into an ALU command plus writeback info and registers it into ID/EX.
// Latency: 1 cycle from capture to out_* (rf_rs*_addr and in_ready are combinational).
// Backpressure: stall holds the ID/EX register and deasserts in_ready; flush squashes the entry and wins over stall.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_instr/in_pc   instruction from IF; in_ready = !stall
//   stall, flush          hazard-unit hold / squash of the ID/EX register
//   rf_rs1/2_addr, rf_rs1/2_data   same-cycle register-file read port
//   out_valid, out_alu_op, out_a, out_b, out_rd, out_reg_write, out_illegal   ID/EX register
module decode_stage #(
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        in_ready,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic        out_valid,
  output logic [2:0]  out_alu_op,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_illegal
);

  // ALU command encodings understood by the EX stage
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_SHL = 3'd4;
  localparam logic [2:0] ALU_SHR = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;

  logic        w_sup;
  logic [2:0]  w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;

  logic        r_valid;
  logic [2:0]  r_alu_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_rd     = in_instr[11:7];
  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_shamt  = {27'b0, in_instr[24:20]};

  assign in_ready    = !stall;
  assign rf_rs1_addr = in_instr[19:15];
  assign rf_rs2_addr = in_instr[24:20];

  // The ALU's SLT is unsigned, so only sltu/sltiu decode to it; signed
  // compares and arithmetic right shifts have no ALU op and are rejected.
  always_comb begin
    w_sup = 1'b0;
    w_op  = ALU_ADD;
    w_a   = rf_rs1_data;
    w_b   = rf_rs2_data;
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == 7'b0000000) begin
          w_sup = 1'b1;
          case (w_f3)
            3'b000:  w_op = ALU_ADD;
            3'b001:  w_op = ALU_SHL;
            3'b011:  w_op = ALU_SLT;
            3'b100:  w_op = ALU_XOR;
            3'b101:  w_op = ALU_SHR;
            3'b110:  w_op = ALU_OR;
            3'b111:  w_op = ALU_AND;
            default: w_sup = 1'b0;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_sup = 1'b1;
          w_op  = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        w_b   = w_imm_i;
        w_sup = 1'b1;
        case (w_f3)
          3'b000: w_op = ALU_ADD;
          3'b011: w_op = ALU_SLT;
          3'b100: w_op = ALU_XOR;
          3'b110: w_op = ALU_OR;
          3'b111: w_op = ALU_AND;
          3'b001: begin
            w_op  = ALU_SHL;
            w_b   = w_shamt;
            w_sup = (w_f7 == 7'b0000000);
          end
          3'b101: begin
            w_op  = ALU_SHR;
            w_b   = w_shamt;
            w_sup = (w_f7 == 7'b0000000);
          end
          default: w_sup = 1'b0;
        endcase
      end
      OPC_LUI: begin
        w_sup = 1'b1;
        w_a   = 32'd0;
        w_b   = w_imm_u;
      end
      OPC_AUIPC: begin
        w_sup = 1'b1;
        w_a   = in_pc;
        w_b   = w_imm_u;
      end
      default: w_sup = 1'b0;
    endcase
    // Rejected encodings always present ADD so EX never sees a stray op
    if (!w_sup) begin
      w_op = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_alu_op    <= ALU_ADD;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!stall) begin
      r_valid     <= in_valid && (w_sup || !ILLEGAL_AS_NOP);
      r_illegal   <= in_valid && !w_sup && !ILLEGAL_AS_NOP;
      // x0 is hard-wired zero, so a write to it is dropped here
      r_reg_write <= in_valid && w_sup && (w_rd != 5'd0);
      r_alu_op    <= w_op;
      r_a         <= w_a;
      r_b         <= w_b;
      r_rd        <= w_rd;
    end
  end

  assign out_valid     = r_valid;
  assign out_alu_op    = r_alu_op;
  assign out_a         = r_a;
  assign out_b         = r_b;
  assign out_rd        = r_rd;
  assign out_reg_write = r_reg_write;
  assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    int          mode;   // 0: v/rw/ill only, 1: plus op, 2: every field
    logic        nv;     // expected out_valid of the ILLEGAL_AS_NOP=1 instance
    logic        nill;   // expected out_illegal of the ILLEGAL_AS_NOP=1 instance
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rf_rs1_data = 32'd0;
  logic [31:0] rf_rs2_data = 32'd0;

  logic        in_ready, n_in_ready;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, n_rs1_addr, n_rs2_addr;
  logic        out_valid, out_reg_write, out_illegal;
  logic [2:0]  out_alu_op;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        n_valid, n_reg_write, n_illegal;
  logic [2:0]  n_alu_op;
  logic [31:0] n_a, n_b;
  logic [4:0]  n_rd;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage #(.ILLEGAL_AS_NOP(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .stall(stall), .flush(flush), .in_ready(in_ready),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .out_valid(out_valid), .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  decode_stage #(.ILLEGAL_AS_NOP(1'b1)) dut_nop (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .stall(stall), .flush(flush), .in_ready(n_in_ready),
    .rf_rs1_addr(n_rs1_addr), .rf_rs2_addr(n_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .out_valid(n_valid), .out_alu_op(n_alu_op), .out_a(n_a), .out_b(n_b),
    .out_rd(n_rd), .out_reg_write(n_reg_write), .out_illegal(n_illegal)
  );

  function automatic exp_t mk(logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic [4:0] rd, logic rw, logic ill, int mode,
                              logic nv, logic nill);
    exp_t e;
    e.v = v; e.op = op; e.a = a; e.b = b; e.rd = rd; e.rw = rw; e.ill = ill;
    e.mode = mode; e.nv = nv; e.nill = nill;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Drive one vector after a falling edge, check the combinational outputs,
  // and queue the registered response expected after the next rising edge.
  task automatic apply(logic rst, logic fl, logic st, logic vld, logic [31:0] instr,
                       logic [31:0] pc, logic [31:0] r1, logic [31:0] r2, exp_t e,
                       logic chk_addr, logic [4:0] ea1, logic [4:0] ea2);
    @(negedge clk);
    reset = rst; flush = fl; stall = st; in_valid = vld; in_instr = instr;
    in_pc = pc; rf_rs1_data = r1; rf_rs2_data = r2;
    sb.push_back(e);
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !st});
    if (chk_addr) begin
      chk("rf_rs1_addr", {27'd0, rf_rs1_addr}, {27'd0, ea1});
      chk("rf_rs2_addr", {27'd0, rf_rs2_addr}, {27'd0, ea2});
    end
  endtask

  // Monitor: after every rising edge compare the ID/EX outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
        chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        chk("nop.out_valid", {31'd0, n_valid}, {31'd0, e.nv});
        chk("nop.out_illegal", {31'd0, n_illegal}, {31'd0, e.nill});
        if (e.mode >= 1) chk("out_alu_op", {29'd0, out_alu_op}, {29'd0, e.op});
        if (e.mode >= 2) begin
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
        end
      end
    end
  end

  initial begin
    exp_t e_add, e_rst;
    int budget;
    e_rst = mk(1'b0, 3'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    e_add = mk(1'b1, 3'd2, 32'd10, 32'd7, 5'd3, 1'b1, 1'b0, 2, 1'b1, 1'b0);

    // reset state
    apply(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, e_rst, 0, 5'd0, 5'd0);
    // ADD x3,x1,x2
    apply(0, 0, 0, 1, 32'h002081B3, 32'h0, 32'd10, 32'd7, e_add, 1, 5'd1, 5'd2);
    // SUB x1,x2,x3
    apply(0, 0, 0, 1, 32'h403100B3, 32'h4, 32'd100, 32'd30,
          mk(1, 3'd6, 32'd100, 32'd30, 5'd1, 1, 0, 2, 1, 0), 1, 5'd2, 5'd3);
    // ADDI x5,x0,-1
    apply(0, 0, 0, 1, 32'hFFF00293, 32'h8, 32'd0, 32'h55,
          mk(1, 3'd2, 32'd0, 32'hFFFFFFFF, 5'd5, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // SLLI x1,x1,3
    apply(0, 0, 0, 1, 32'h00309093, 32'hC, 32'd5, 32'h77,
          mk(1, 3'd4, 32'd5, 32'd3, 5'd1, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // LUI x2,0x12345 (a forced to 0 despite rs1 data)
    apply(0, 0, 0, 1, 32'h12345137, 32'h100, 32'hDEAD, 32'h0,
          mk(1, 3'd2, 32'd0, 32'h12345000, 5'd2, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // AUIPC x3,0x12345 at pc 0x100
    apply(0, 0, 0, 1, 32'h12345197, 32'h100, 32'hDEAD, 32'h0,
          mk(1, 3'd2, 32'h100, 32'h12345000, 5'd3, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // SLT (signed) is unsupported
    apply(0, 0, 0, 1, 32'h0020A1B3, 32'h0, 32'd3, 32'd9,
          mk(1, 3'd2, 32'd0, 32'd0, 5'd0, 0, 1, 1, 0, 0), 0, 5'd0, 5'd0);
    // SLTU x3,x1,x2 maps to SLT
    apply(0, 0, 0, 1, 32'h0020B1B3, 32'h0, 32'd3, 32'd9,
          mk(1, 3'd7, 32'd3, 32'd9, 5'd3, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // SRAI x1,x1,1 is unsupported
    apply(0, 0, 0, 1, 32'h4010D093, 32'h0, 32'd3, 32'd9,
          mk(1, 3'd2, 32'd0, 32'd0, 5'd0, 0, 1, 1, 0, 0), 0, 5'd0, 5'd0);
    // XORI x4,x2,0x0F0
    apply(0, 0, 0, 1, 32'h0F014213, 32'h0, 32'hFF, 32'd0,
          mk(1, 3'd3, 32'hFF, 32'hF0, 5'd4, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // ANDI x6,x1,-16
    apply(0, 0, 0, 1, 32'hFF00F313, 32'h0, 32'h1234, 32'd0,
          mk(1, 3'd0, 32'h1234, 32'hFFFFFFF0, 5'd6, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // capture ADD, then stall three cycles while the input changes
    apply(0, 0, 0, 1, 32'h002081B3, 32'h0, 32'd10, 32'd7, e_add, 0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      apply(0, 0, 1, 1, 32'h403100B3, 32'h4, 32'd100, 32'd30, e_add, 0, 5'd0, 5'd0);
    // stall released: SUB captured one cycle later
    apply(0, 0, 0, 1, 32'h403100B3, 32'h4, 32'd100, 32'd30,
          mk(1, 3'd6, 32'd100, 32'd30, 5'd1, 1, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // flush wins over stall
    apply(0, 1, 1, 1, 32'h002081B3, 32'h0, 32'd10, 32'd7,
          mk(0, 3'd2, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0), 0, 5'd0, 5'd0);
    // ADD x0,x1,x2: valid but no writeback
    apply(0, 0, 0, 1, 32'h00208033, 32'h0, 32'd1, 32'd2,
          mk(1, 3'd2, 32'd1, 32'd2, 5'd0, 0, 0, 2, 1, 0), 0, 5'd0, 5'd0);
    // in_valid low on capture
    apply(0, 0, 0, 0, 32'h002081B3, 32'h0, 32'd10, 32'd7,
          mk(0, 3'd2, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0), 0, 5'd0, 5'd0);
    // valid entry, then reset while stalled
    apply(0, 0, 0, 1, 32'h002081B3, 32'h0, 32'd10, 32'd7, e_add, 0, 5'd0, 5'd0);
    apply(1, 1, 1, 1, 32'h002081B3, 32'h0, 32'd10, 32'd7, e_rst, 0, 5'd0, 5'd0);

    @(negedge clk);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
